// File: rtl/decode_regfile_reader.sv
// rtl/decode_regfile_reader.sv - Y86-64 register file read side with write-back bypass and D->E pipeline register.
// Optional DECODE_FWD_EN adds e/M-stage forwarding ports ahead of the W-stage bypass.
module decode_regfile_reader #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int RSP_ID = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               D_icode,
    input  logic [3:0]               D_ifun,
    input  logic [3:0]               D_rA,
    input  logic [3:0]               D_rB,
    input  logic [DATA_W-1:0]        D_valC,
    input  logic [DATA_W-1:0]        D_valP,
    input  logic [3:0]               W_dstE,
    input  logic [DATA_W-1:0]        W_valE,
    input  logic [3:0]               W_dstM,
    input  logic [DATA_W-1:0]        W_valM,
`ifdef DECODE_FWD_EN
    input  logic [3:0]               e_dstE,
    input  logic [DATA_W-1:0]        e_valE,
    input  logic [3:0]               M_dstM,
    input  logic [DATA_W-1:0]        m_valM,
    input  logic [3:0]               M_dstE,
    input  logic [DATA_W-1:0]        M_valE,
`endif
    input  logic                     E_stall,
    input  logic                     E_bubble,
    output logic [3:0]               d_srcA,
    output logic [3:0]               d_srcB,
    output logic [3:0]               E_icode,
    output logic [3:0]               E_ifun,
    output logic [DATA_W-1:0]        E_valC,
    output logic [DATA_W-1:0]        E_valA,
    output logic [DATA_W-1:0]        E_valB,
    output logic [3:0]               E_dstE,
    output logic [3:0]               E_dstM,
    output logic [3:0]               E_srcA,
    output logic [3:0]               E_srcB,
    output logic [NREG*DATA_W-1:0]   rf_dbg
);
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RSP     = 4'(RSP_ID);
    localparam logic [3:0] I_NOP   = 4'h1;

    logic [DATA_W-1:0] rf [NREG];
    logic [3:0]        src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] rd_a, rd_b, val_a, val_b;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            4'h2: begin src_a = D_rA; dst_e = D_rB; end
            4'h3: dst_e = D_rB;
            4'h4: begin src_a = D_rA; src_b = D_rB; end
            4'h5: begin src_b = D_rB; dst_m = D_rA; end
            4'h6: begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            4'h8: begin src_b = RSP; dst_e = RSP; end
            4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            4'hA: begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
            4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
            default: ;
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    // RNONE never matches an array index, so an unused source reads as zero.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (src_a == 4'(i)) rd_a = rf[i];
            if (src_b == 4'(i)) rd_b = rf[i];
        end
    end

    always_comb begin
        val_a = rd_a;
        if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
`ifdef DECODE_FWD_EN
        else if (src_a != RNONE && src_a == e_dstE) val_a = e_valE;
        else if (src_a != RNONE && src_a == M_dstM) val_a = m_valM;
        else if (src_a != RNONE && src_a == M_dstE) val_a = M_valE;
`endif
        else if (src_a != RNONE && src_a == W_dstM) val_a = W_valM;
        else if (src_a != RNONE && src_a == W_dstE) val_a = W_valE;
    end

    always_comb begin
        val_b = rd_b;
        if (1'b0) val_b = rd_b;
`ifdef DECODE_FWD_EN
        else if (src_b != RNONE && src_b == e_dstE) val_b = e_valE;
        else if (src_b != RNONE && src_b == M_dstM) val_b = m_valM;
        else if (src_b != RNONE && src_b == M_dstE) val_b = M_valE;
`endif
        else if (src_b != RNONE && src_b == W_dstM) val_b = W_valM;
        else if (src_b != RNONE && src_b == W_dstE) val_b = W_valE;
    end

    // M port takes precedence so popq %rsp leaves the loaded value in %rsp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (W_dstM == 4'(i))      rf[i] <= W_valM;
                else if (W_dstE == 4'(i)) rf[i] <= W_valE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || E_bubble) begin
            E_icode <= I_NOP;
            E_ifun  <= '0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else if (!E_stall) begin
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= val_a;
            E_valB  <= val_b;
            E_dstE  <= dst_e;
            E_dstM  <= dst_m;
            E_srcA  <= src_a;
            E_srcB  <= src_b;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_dbg
        assign rf_dbg[g*DATA_W +: DATA_W] = rf[g];
    end
endmodule

// File: tb/tb_decode_regfile_reader.sv
// tb/tb_decode_regfile_reader.sv - directed plus random checks of decode_regfile_reader against a behavioural model.
module tb_decode_regfile_reader;
    logic         clk, rst_n;
    logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
    logic [63:0]  D_valC, D_valP;
    logic [3:0]   W_dstE, W_dstM;
    logic [63:0]  W_valE, W_valM;
    logic         E_stall, E_bubble;
    logic [3:0]   d_srcA, d_srcB;
    logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0]  E_valC, E_valA, E_valB;
    logic [15*64-1:0] rf_dbg;

    decode_regfile_reader dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA),
        .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA),
        .E_srcB(E_srcB), .rf_dbg(rf_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode, ifun, dstE, dstM, srcA, srcB;
        logic [63:0] valC, valA, valB;
    } e_t;

    logic [63:0] m_rf [15];
    e_t          m_e;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic e_t bubble();
        e_t r;
        r.icode = 4'h1; r.ifun = 4'h0; r.valC = 64'h0; r.valA = 64'h0; r.valB = 64'h0;
        r.dstE = 4'hF; r.dstM = 4'hF; r.srcA = 4'hF; r.srcB = 4'hF;
        return r;
    endfunction

    // Architectural read as the decode stage sees it: newest write-back value wins.
    function automatic logic [63:0] model_read(input logic [3:0] s);
        if (s == 4'hF) return 64'h0;
        if (W_dstM == s) return W_valM;
        if (W_dstE == s) return W_valE;
        return m_rf[s];
    endfunction

    function automatic e_t model_decode();
        e_t r;
        logic [3:0] ic;
        ic = D_icode;
        r.icode = ic; r.ifun = D_ifun; r.valC = D_valC;
        r.srcA = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? D_rA : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        r.srcB = (ic inside {4'h4, 4'h5, 4'h6}) ? D_rB : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        r.dstE = (ic inside {4'h2, 4'h3, 4'h6}) ? D_rB : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        r.dstM = (ic inside {4'h5, 4'hB}) ? D_rA : 4'hF;
        r.valA = (ic inside {4'h7, 4'h8}) ? D_valP : model_read(r.srcA);
        r.valB = model_read(r.srcB);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_rf[i] = 64'h0;
        m_e = bubble();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".icode"}, 64'(E_icode), 64'(m_e.icode));
        chk({tag, ".ifun"},  64'(E_ifun),  64'(m_e.ifun));
        chk({tag, ".valC"},  E_valC, m_e.valC);
        chk({tag, ".valA"},  E_valA, m_e.valA);
        chk({tag, ".valB"},  E_valB, m_e.valB);
        chk({tag, ".dstE"},  64'(E_dstE), 64'(m_e.dstE));
        chk({tag, ".dstM"},  64'(E_dstM), 64'(m_e.dstM));
        chk({tag, ".srcA"},  64'(E_srcA), 64'(m_e.srcA));
        chk({tag, ".srcB"},  64'(E_srcB), 64'(m_e.srcB));
        for (int i = 0; i < 15; i++)
            chk($sformatf("%s.rf%0d", tag, i), rf_dbg[i*64 +: 64], m_rf[i]);
    endtask

    task automatic cycle(input string tag);
        e_t dec, nxt;
        #1;
        dec = model_decode();
        chk({tag, ".d_srcA"}, 64'(d_srcA), 64'(dec.srcA));
        chk({tag, ".d_srcB"}, 64'(d_srcB), 64'(dec.srcB));
        nxt = E_bubble ? bubble() : (E_stall ? m_e : dec);
        @(posedge clk);
        m_e = nxt;
        if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
        if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
        #1;
        check_state(tag);
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
        D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
    endtask

    task automatic set_w(input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [3:0] rnd_dst();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    endfunction

    logic [63:0] held_a, held_b;

    initial begin
        rst_n = 1'b0; E_stall = 1'b0; E_bubble = 1'b0;
        set_d(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        set_w(4'hF, 64'h0, 4'hF, 64'h0);
        model_reset();
        #12;
        check_state("reset");
        chk("reset.E_icode_nop", 64'(E_icode), 64'h1);
        chk("reset.rf_zero", 64'(rf_dbg == '0), 64'h1);
        rst_n = 1'b1;

        set_w(4'h3, 64'd25, 4'hF, 64'h0);
        cycle("t2a");
        set_w(4'hF, 64'h0, 4'hF, 64'h0);
        set_d(4'h6, 4'h0, 4'h1, 4'h3, 64'h0, 64'h0);
        cycle("t2b");
        chk("t2.valB", E_valB, 64'd25);
        chk("t2.dstE", 64'(E_dstE), 64'h3);
        chk("t2.srcA", 64'(E_srcA), 64'h1);

        set_w(4'hF, 64'h0, 4'h2, 64'd7);
        set_d(4'h2, 4'h0, 4'h2, 4'h5, 64'h0, 64'h0);
        cycle("t3");
        chk("t3.valA", E_valA, 64'd7);
        chk("t3.rf2", rf_dbg[2*64 +: 64], 64'd7);

        set_w(4'h4, 64'd8, 4'h4, 64'd99);
        set_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h40);
        cycle("t4");
        chk("t4.rf4", rf_dbg[4*64 +: 64], 64'd99);
        chk("t4.valA", E_valA, 64'h40);
        chk("t4.dstE", 64'(E_dstE), 64'h4);
        chk("t4.valB", E_valB, 64'd99);

        set_w(4'hF, 64'h0, 4'hF, 64'h0);
        set_d(4'h6, 4'h1, 4'h2, 4'h4, 64'h0, 64'h0);
        cycle("t5load");
        held_a = E_valA; held_b = E_valB;
        E_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_d(4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 14)),
                  4'($urandom_range(0, 14)), rnd64(), rnd64());
            cycle($sformatf("t5stall%0d", k));
            chk("t5.held_valA", E_valA, 64'd7);
            chk("t5.held_valB", E_valB, 64'd99);
            chk("t5.held_icode", 64'(E_icode), 64'h6);
        end
        E_bubble = 1'b1;
        cycle("t5bub");
        chk("t5.bub_icode", 64'(E_icode), 64'h1);
        chk("t5.bub_dstE", 64'(E_dstE), 64'hF);
        E_stall = 1'b0; E_bubble = 1'b0;

        for (int n = 0; n < 300; n++) begin
            set_d(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), rnd64(), rnd64());
            set_w(rnd_dst(), rnd64(), rnd_dst(), rnd64());
            E_stall  = ($urandom_range(0, 7) == 0);
            E_bubble = ($urandom_range(0, 9) == 0);
            cycle($sformatf("rnd%0d", n));
        end

        E_stall = 1'b0; E_bubble = 1'b0;
        set_w(4'h5, 64'h1234, 4'hF, 64'h0);
        set_d(4'h6, 4'h2, 4'h5, 4'h7, 64'h55, 64'h0);
        cycle("t6load");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("t6async");
        #2;
        rst_n = 1'b1;
        set_w(4'hF, 64'h0, 4'hF, 64'h0);
        cycle("t6after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
